// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// seg_scan_ctrl: multiplexed 7-segment scan controller with dark inter-digit gap
// and per-frame pulse. Revision 1.0
module seg_scan_ctrl #(
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_DIV   = 100000,
  parameter int GAP_CYC    = 2000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [2:0]            wr_idx,
  input  logic [3:0]            wr_val,
  input  logic [NUM_DIGITS-1:0] blank_mask,
  input  logic [NUM_DIGITS-1:0] dp_mask,
  output logic [3:0]            code_out,
  input  logic [7:0]            seg_in,
  output logic [7:0]            seg_out,
  output logic [NUM_DIGITS-1:0] an_out,
  output logic                  frame_done
);

  localparam int IDX_W   = $clog2(NUM_DIGITS);
  localparam int CNT_MAX = (SCAN_DIV > GAP_CYC) ? SCAN_DIV : GAP_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0] SHOW_LAST    = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(NUM_DIGITS - 1);
  localparam logic [3:0]       NUM_DIGITS_W = 4'(NUM_DIGITS);
  localparam logic [NUM_DIGITS-1:0] AN_ONE  = {{(NUM_DIGITS-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    SHOW = 1'b0,
    GAP  = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] div_cnt, div_cnt_nxt;
  logic [IDX_W-1:0] scan_idx, scan_idx_nxt;
  logic             wrap;
  logic             lit;
  logic [3:0]       val [NUM_DIGITS];

  // Decoder's dp bit is deliberately discarded; dp comes from dp_mask.
  logic unused_seg_dp;
  assign unused_seg_dp = seg_in[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_DIGITS; i++) val[i] <= 4'd0;
    end else if (wr_en && ({1'b0, wr_idx} < NUM_DIGITS_W)) begin
      val[wr_idx[IDX_W-1:0]] <= wr_val;
    end
  end

  assign code_out = val[scan_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= SHOW;
      div_cnt    <= '0;
      scan_idx   <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      div_cnt    <= div_cnt_nxt;
      scan_idx   <= scan_idx_nxt;
      frame_done <= wrap;
    end
  end

  always_comb begin
    state_nxt    = state;
    div_cnt_nxt  = div_cnt + CNT_W'(1);
    scan_idx_nxt = scan_idx;
    wrap         = 1'b0;
    case (state)
      SHOW: begin
        if (div_cnt == SHOW_LAST) begin
          state_nxt   = GAP;
          div_cnt_nxt = '0;
        end
      end
      GAP: begin
        if (div_cnt == GAP_LAST) begin
          state_nxt   = SHOW;
          div_cnt_nxt = '0;
          if (scan_idx == IDX_LAST) begin
            scan_idx_nxt = '0;
            wrap         = 1'b1;
          end else begin
            scan_idx_nxt = scan_idx + IDX_W'(1);
          end
        end
      end
      default: begin
        state_nxt   = SHOW;
        div_cnt_nxt = '0;
      end
    endcase
  end

  // Anode and segments are registered together so they never disagree on digit.
  assign lit = (state == SHOW) && !blank_mask[scan_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      an_out  <= '0;
      seg_out <= 8'd0;
    end else if (lit) begin
      an_out  <= AN_ONE << scan_idx;
      seg_out <= {seg_in[7:1], dp_mask[scan_idx]};
    end else begin
      an_out  <= '0;
      seg_out <= 8'd0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// tb_seg_scan_ctrl: randomized check of seg_scan_ctrl (8- and 6-digit builds)
// against a time-based reference model. Revision 1.0
module tb_seg_scan_ctrl;

  localparam int SDIV = 4;
  localparam int GAPC = 2;
  localparam int PER  = SDIV + GAPC;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [2:0] wr_idx = 3'd0;
  logic [3:0] wr_val = 4'd0;
  logic [7:0] blank_mask = 8'd0;
  logic [7:0] dp_mask = 8'd0;
  logic       junk8 = 1'b0;
  logic       junk6 = 1'b0;

  logic [3:0] code8, code6;
  logic [7:0] seg_in8, seg_in6, seg8, seg6;
  logic [7:0] an8;
  logic [5:0] an6;
  logic       fd8, fd6;

  int total = 0;
  int bad   = 0;

  int         mc [2];
  logic [3:0] mval [2][8];

  always #5 clk = ~clk;

  function automatic logic [6:0] dec7(input logic [3:0] c);
    case (c)
      4'd0: dec7 = 7'b1111110;
      4'd1: dec7 = 7'b0110000;
      4'd2: dec7 = 7'b1101101;
      4'd3: dec7 = 7'b1111001;
      4'd4: dec7 = 7'b0110011;
      4'd5: dec7 = 7'b1011011;
      4'd6: dec7 = 7'b1011111;
      4'd7: dec7 = 7'b1110000;
      4'd8: dec7 = 7'b1111111;
      4'd9: dec7 = 7'b1110011;
      default: dec7 = 7'b1001111;
    endcase
  endfunction

  assign seg_in8 = {dec7(code8), junk8};
  assign seg_in6 = {dec7(code6), junk6};

  seg_scan_ctrl #(.NUM_DIGITS(8), .SCAN_DIV(SDIV), .GAP_CYC(GAPC)) u_dut8 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_idx(wr_idx), .wr_val(wr_val),
    .blank_mask(blank_mask), .dp_mask(dp_mask), .code_out(code8),
    .seg_in(seg_in8), .seg_out(seg8), .an_out(an8), .frame_done(fd8)
  );

  seg_scan_ctrl #(.NUM_DIGITS(6), .SCAN_DIV(SDIV), .GAP_CYC(GAPC)) u_dut6 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_idx(wr_idx), .wr_val(wr_val),
    .blank_mask(blank_mask[5:0]), .dp_mask(dp_mask[5:0]), .code_out(code6),
    .seg_in(seg_in6), .seg_out(seg6), .an_out(an6), .frame_done(fd6)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock: predict outputs from pre-edge model state, then advance the model.
  task automatic tick();
    logic [7:0] e_an [2];
    logic [7:0] e_seg [2];
    logic       e_fd [2];
    int n, f, p, d, ph;
    bit show;
    junk8 = 1'($urandom);
    junk6 = 1'($urandom);
    for (int k = 0; k < 2; k++) begin
      n = (k == 0) ? 8 : 6;
      f = n * PER;
      p = mc[k] % f;
      d = p / PER;
      ph = p % PER;
      show = !rst && (ph < SDIV) && !blank_mask[d];
      e_an[k]  = show ? 8'(1 << d) : 8'd0;
      e_seg[k] = show ? {dec7(mval[k][d]), dp_mask[d]} : 8'd0;
      e_fd[k]  = !rst && (p == f - 1);
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      n = (k == 0) ? 8 : 6;
      if (rst) begin
        mc[k] = 0;
        for (int i = 0; i < 8; i++) mval[k][i] = 4'd0;
      end else begin
        if (wr_en && (int'(wr_idx) < n)) mval[k][wr_idx] = wr_val;
        mc[k]++;
      end
    end
    check("an8",   32'(an8),  32'(e_an[0]));
    check("seg8",  32'(seg8), 32'(e_seg[0]));
    check("fd8",   32'(fd8),  32'(e_fd[0]));
    check("code8", 32'(code8), 32'(mval[0][(mc[0] % (8 * PER)) / PER]));
    check("an6",   32'(an6),  32'(e_an[1][5:0]));
    check("seg6",  32'(seg6), 32'(e_seg[1]));
    check("fd6",   32'(fd6),  32'(e_fd[1]));
    check("code6", 32'(code6), 32'(mval[1][(mc[1] % (6 * PER)) / PER]));
    @(negedge clk);
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) tick();
  endtask

  task automatic write(input logic [2:0] idx, input logic [3:0] v);
    wr_en = 1'b1; wr_idx = idx; wr_val = v;
    tick();
    wr_en = 1'b0;
  endtask

  // Advance (bounded) until the 8-digit model sits at the given frame position.
  task automatic seek(input int pos);
    for (int i = 0; i < 8 * PER && (mc[0] % (8 * PER)) != pos; i++) tick();
    check("seek", 32'(mc[0] % (8 * PER)), 32'(pos));
  endtask

  initial begin
    int fcnt;
    for (int k = 0; k < 2; k++) begin
      mc[k] = 0;
      for (int i = 0; i < 8; i++) mval[k][i] = 4'd0;
    end
    @(negedge clk);
    rst = 1'b1;
    run(2);
    rst = 1'b0;

    // Free run from reset: two frame pulses in 96 cycles.
    fcnt = 0;
    for (int i = 0; i < 96; i++) begin
      tick();
      if (fd8) fcnt++;
    end
    check("fd_count", 32'(fcnt), 32'd2);

    dp_mask = 8'b0000_1000;
    write(3'd3, 4'd7);
    write(3'd5, 4'd12);
    run(48);

    blank_mask = 8'b0000_0100;
    run(48);
    blank_mask = 8'd0;
    dp_mask = 8'd0;

    // Write to digit 1 while it is being shown; idx 7 is out of range for the 6-digit build.
    seek(1 * PER + 1);
    write(3'd1, 4'd9);
    run(4);
    write(3'd7, 4'd3);
    run(48);

    // Reset mid-gap of digit 4 with a concurrent write that must be discarded.
    seek(4 * PER + SDIV);
    rst = 1'b1; wr_en = 1'b1; wr_idx = 3'd0; wr_val = 4'd5;
    tick();
    rst = 1'b0; wr_en = 1'b0;
    run(12);

    for (int i = 0; i < 800; i++) begin
      wr_en  = ($urandom % 4) == 0;
      wr_idx = 3'($urandom);
      wr_val = 4'($urandom);
      if (($urandom % 8) == 0) blank_mask = 8'($urandom);
      if (($urandom % 8) == 0) dp_mask = 8'($urandom);
      rst = ($urandom % 150) == 0;
      tick();
    end
    rst = 1'b0;
    wr_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
